mc_control: RTL and testbench

//  Multicycle RV32I controller: next generation of the single-cycle control unit. Sequences

---
 rtl/rv_ctrl_pkg.sv | 74 +++++++
 rtl/mc_control_aludec_ext.sv | 42 ++++
 rtl/mc_control.sv | 212 +++++++++++++++++++++
 tb/tb_mc_control.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_ctrl_pkg.sv
// Shared encodings for the multicycle RV32I controller: opcodes, FSM states,
// ALU operation codes, immediate formats and datapath mux-select codes.
// Pure declarations; no timing or flow-control behaviour of its own.
package rv_ctrl_pkg;

    // Major opcodes (IR[6:0])
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // Exactly 16 states, so a 4-bit encoding has no unused codes.
    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
        S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR1, S_JALR2,
        S_LUI, S_AUIPC, S_ILLEGAL
    } state_t;

    // ALUOp: what the ALU decoder should do this cycle
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALUControl codes (zero-extended to ALUCTRL_W at the port)
    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // Immediate formats
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    // Datapath mux selects
    localparam logic       ADR_PC        = 1'b0;
    localparam logic       ADR_ALUOUT    = 1'b1;
    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;
    localparam logic [1:0] SRCA_PC       = 2'b00;
    localparam logic [1:0] SRCA_OLDPC    = 2'b01;
    localparam logic [1:0] SRCA_RS1      = 2'b10;
    localparam logic [1:0] SRCA_ZERO     = 2'b11;
    localparam logic [1:0] SRCB_RS2      = 2'b00;
    localparam logic [1:0] SRCB_IMM      = 2'b01;
    localparam logic [1:0] SRCB_FOUR     = 2'b10;

    // Immediate format implied by the opcode; formats without an immediate
    // fall back to I, which the datapath ignores for those instructions.
    function automatic logic [2:0] imm_src(input logic [6:0] op);
        case (op)
            OP_STORE:          imm_src = IMM_S;
            OP_BRANCH:         imm_src = IMM_B;
            OP_JAL:            imm_src = IMM_J;
            OP_LUI, OP_AUIPC:  imm_src = IMM_U;
            default:           imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_control_aludec_ext.sv
// ALU decoder: maps ALUOp plus funct3/funct7b5/op[5] onto an ALUControl code.
// Latency: purely combinational, zero cycles.
// Backpressure: none; follows its inputs every cycle.
// Ports: aluop (2) in, funct3 (3) in, funct7b5 in, op5 in, alucontrol (ALUCTRL_W) out.
module aludec_ext
    import rv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4
) (
    input  logic [1:0]           aluop,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 op5,
    output logic [ALUCTRL_W-1:0] alucontrol
);

    logic [3:0] code;

    always_comb begin
        code = ALU_ADD;
        case (aluop)
            ALUOP_SUB: code = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7b5 is an immediate bit for I-type, so sub needs op[5] too
                    3'b000:  code = (op5 & funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b001:  code = ALU_SLL;
                    3'b010:  code = ALU_SLT;
                    3'b011:  code = ALU_SLTU;
                    3'b100:  code = ALU_XOR;
                    3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  code = ALU_OR;
                    default: code = ALU_AND;
                endcase
            end
            default: code = ALU_ADD;
        endcase
    end

    assign alucontrol = ALUCTRL_W'(code);

endmodule

// File: rtl/mc_control.sv
// Multicycle RV32I controller: sequences each instruction, drives mux selects/enables, traps illegal ops.
// Latency: 3 (branch) to 5 (lw, jalr) cycles per instruction with zero wait states.
// Backpressure: FETCH, MEMREAD and MEMWRITE hold until mem_ready (ignored when MEM_HS=0).
// Ports: clk, rst_n (sync, active-low); op/funct3/funct7b5 from IR; zero/lt/ltu ALU flags;
//        mem_ready; write enables, mux selects, ImmSrc, ALUControl; instr_done, illegal, instret.
module mc_control
    import rv_ctrl_pkg::*;
#(
    parameter int ALUCTRL_W = 4,
    parameter int CNT_W     = 32,
    parameter int MEM_HS    = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7b5,
    input  logic                 zero,
    input  logic                 lt,
    input  logic                 ltu,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 IRWrite,
    output logic                 MemWrite,
    output logic                 RegWrite,
    output logic                 AdrSrc,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ImmSrc,
    output logic [ALUCTRL_W-1:0] ALUControl,
    output logic                 instr_done,
    output logic                 illegal,
    output logic [CNT_W-1:0]     instret
);

    state_t     state;
    logic       ready;
    logic       br_legal, br_taken;
    logic       pcw, irw, mw, rw, done;
    logic [1:0] aluop;

    assign ready = (MEM_HS != 0) ? mem_ready : 1'b1;

    // funct3 010/011 are not branches; they trap rather than retire.
    always_comb begin
        br_legal = 1'b1;
        br_taken = 1'b0;
        case (funct3)
            3'b000:  br_taken = zero;
            3'b001:  br_taken = ~zero;
            3'b100:  br_taken = lt;
            3'b101:  br_taken = ~lt;
            3'b110:  br_taken = ltu;
            3'b111:  br_taken = ~ltu;
            default: br_legal = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= S_FETCH;
            instret <= '0;
            illegal <= 1'b0;
        end else begin
            case (state)
                S_FETCH:    if (ready) state <= S_DECODE;
                S_DECODE: begin
                    case (op)
                        OP_LOAD, OP_STORE: state <= S_MEMADR;
                        OP_RTYPE:          state <= S_EXECR;
                        OP_ITYPE:          state <= S_EXECI;
                        OP_JAL:            state <= S_JAL;
                        OP_JALR:           state <= S_JALR1;
                        OP_BRANCH:         state <= S_BRANCH;
                        OP_LUI:            state <= S_LUI;
                        OP_AUIPC:          state <= S_AUIPC;
                        default:           state <= S_ILLEGAL;
                    endcase
                end
                // op[5] separates sw (0100011) from lw (0000011)
                S_MEMADR:   state <= op[5] ? S_MEMWRITE : S_MEMREAD;
                S_MEMREAD:  if (ready) state <= S_MEMWB;
                S_MEMWB:    state <= S_FETCH;
                S_MEMWRITE: if (ready) state <= S_FETCH;
                S_EXECR:    state <= S_ALUWB;
                S_EXECI:    state <= S_ALUWB;
                S_ALUWB:    state <= S_FETCH;
                S_BRANCH:   state <= br_legal ? S_FETCH : S_ILLEGAL;
                S_JAL:      state <= S_ALUWB;
                S_JALR1:    state <= S_JALR2;
                S_JALR2:    state <= S_ALUWB;
                S_LUI:      state <= S_ALUWB;
                S_AUIPC:    state <= S_ALUWB;
                S_ILLEGAL: begin
                    state   <= S_ILLEGAL;
                    illegal <= 1'b1;
                end
                default:    state <= S_FETCH;
            endcase
            if (done) instret <= instret + CNT_W'(1);
        end
    end

    always_comb begin
        pcw       = 1'b0;
        irw       = 1'b0;
        mw        = 1'b0;
        rw        = 1'b0;
        done      = 1'b0;
        AdrSrc    = ADR_PC;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        aluop     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcA   = SRCA_PC;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                pcw       = ready;
                irw       = ready;
            end
            S_DECODE: begin
                // precompute the branch target into ALUOut
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD:  AdrSrc = ADR_ALUOUT;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                rw        = 1'b1;
                done      = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc = ADR_ALUOUT;
                mw     = 1'b1;
                done   = ready;
            end
            S_EXECR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                aluop   = ALUOP_FUNCT;
            end
            S_EXECI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                aluop   = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                rw   = 1'b1;
                done = 1'b1;
            end
            S_BRANCH: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_RS2;
                aluop   = ALUOP_SUB;
                pcw     = br_taken;
                done    = br_legal;
            end
            S_JAL: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pcw     = 1'b1;
            end
            S_JALR1: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_JALR2: begin
                // ALUOut holds rs1+imm; ALUResult computes the link value
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_FOUR;
                pcw     = 1'b1;
            end
            S_LUI: begin
                ALUSrcA = SRCA_ZERO;
                ALUSrcB = SRCB_IMM;
            end
            S_AUIPC: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            default: ;
        endcase
    end

    assign ImmSrc = imm_src(op);

    // Reset suppresses every side effect combinationally, so an aborted
    // instruction can never write state during the reset cycle.
    assign PCWrite    = pcw  & rst_n;
    assign IRWrite    = irw  & rst_n;
    assign MemWrite   = mw   & rst_n;
    assign RegWrite   = rw   & rst_n;
    assign instr_done = done & rst_n;

    aludec_ext #(
        .ALUCTRL_W (ALUCTRL_W)
    ) u_aludec (
        .aluop      (aluop),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .op5        (op[5]),
        .alucontrol (ALUControl)
    );

endmodule

// File: tb/tb_mc_control.sv
module tb_mc_control;

    localparam logic [6:0] OR_ = 7'b0110011;
    localparam logic [6:0] OI  = 7'b0010011;
    localparam logic [6:0] OL  = 7'b0000011;
    localparam logic [6:0] OS  = 7'b0100011;
    localparam logic [6:0] OB  = 7'b1100011;
    localparam logic [6:0] OJ  = 7'b1101111;
    localparam logic [6:0] OJR = 7'b1100111;
    localparam logic [6:0] OLU = 7'b0110111;
    localparam logic [6:0] OAU = 7'b0010111;
    localparam logic [6:0] OBAD = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5, zero, lt, ltu, mem_ready;
    logic       PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB;
    logic [2:0] ImmSrc;
    logic [3:0] ALUControl;
    logic       instr_done, illegal;
    logic [3:0] instret;

    always #5 clk = ~clk;

    mc_control #(.ALUCTRL_W(4), .CNT_W(4), .MEM_HS(1)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7b5(funct7b5),
        .zero(zero), .lt(lt), .ltu(ltu), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .IRWrite(IRWrite), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .AdrSrc(AdrSrc), .ResultSrc(ResultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ImmSrc(ImmSrc), .ALUControl(ALUControl), .instr_done(instr_done),
        .illegal(illegal), .instret(instret)
    );

    // One record per clock cycle: inputs, then the expected outputs in that cycle.
    typedef struct packed {
        logic       rst;
        logic [6:0] op;
        logic [2:0] f3;
        logic       f7;
        logic [2:0] flg;   // {zero, lt, ltu}
        logic       rdy;
        logic [3:0] en;    // {PCWrite, IRWrite, MemWrite, RegWrite}
        logic       adr;
        logic [1:0] res;
        logic [1:0] a;
        logic [1:0] b;
        logic [3:0] alu;
        logic       done;
        logic       ill;
        logic       chk_imm;
        logic [2:0] imm;
    } vec_t;

    vec_t vq[$];
    int   checks = 0;
    int   errors = 0;
    logic [3:0] exp_cnt;

    task automatic chk(input string name, input int idx, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s at step %0d: got %h expected %h", name, idx, got, exp);
        end
    endtask

    task automatic v(input logic rst, input logic [6:0] o, input logic [2:0] f3, input logic f7,
                     input logic [2:0] flg, input logic rdy, input logic [3:0] en, input logic adr,
                     input logic [1:0] res, input logic [1:0] a, input logic [1:0] b,
                     input logic [3:0] alu, input logic done, input logic ill);
        vec_t t;
        t.rst = rst; t.op = o; t.f3 = f3; t.f7 = f7; t.flg = flg; t.rdy = rdy;
        t.en = en; t.adr = adr; t.res = res; t.a = a; t.b = b; t.alu = alu;
        t.done = done; t.ill = ill; t.chk_imm = 1'b0; t.imm = 3'b000;
        vq.push_back(t);
    endtask

    // FETCH (ready) then DECODE for one instruction
    task automatic fd(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic [2:0] flg,
                      input logic ci, input logic [2:0] imm);
        v(1, o, f3, f7, flg, 1, 4'b1100, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0, 0);
        v(1, o, f3, f7, flg, 1, 4'b0000, 0, 2'b00, 2'b01, 2'b01, 4'd0, 0, 0);
        vq[vq.size()-1].chk_imm = ci;
        vq[vq.size()-1].imm     = imm;
    endtask

    // ALUWB writeback cycle
    task automatic wb(input logic [6:0] o, input logic [2:0] f3, input logic f7);
        v(1, o, f3, f7, 3'b000, 1, 4'b0001, 0, 2'b00, 2'b00, 2'b00, 4'd0, 1, 0);
    endtask

    initial begin
        rst_n = 1'b0; op = '0; funct3 = '0; funct7b5 = 1'b0;
        zero = 1'b0; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;

        // reset held in FETCH with ready high: enables still low
        v(0, OR_, 0, 0, 0, 1, 4'b0000, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0, 0);
        // add
        fd(OR_, 3'd0, 0, 0, 0, 3'b000);
        v(1, OR_, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b00, 4'd0, 0, 0);
        wb(OR_, 3'd0, 0);
        // sra
        fd(OR_, 3'd5, 1, 0, 0, 3'b000);
        v(1, OR_, 3'd5, 1, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b00, 4'd9, 0, 0);
        wb(OR_, 3'd5, 1);
        // srli
        fd(OI, 3'd5, 0, 0, 1, 3'b000);
        v(1, OI, 3'd5, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b01, 4'd8, 0, 0);
        wb(OI, 3'd5, 0);
        // addi with imm bit 30 set: still add
        fd(OI, 3'd0, 1, 0, 1, 3'b000);
        v(1, OI, 3'd0, 1, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0, 0);
        wb(OI, 3'd0, 1);
        // lw with three wait states in MEMREAD
        fd(OL, 3'd2, 0, 0, 1, 3'b000);
        v(1, OL, 3'd2, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0, 0);
        for (int k = 0; k < 3; k++)
            v(1, OL, 3'd2, 0, 0, 0, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
        v(1, OL, 3'd2, 0, 0, 1, 4'b0000, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
        v(1, OL, 3'd2, 0, 0, 1, 4'b0001, 0, 2'b01, 2'b00, 2'b00, 4'd0, 1, 0);
        // sw with a FETCH wait and one MEMWRITE wait
        v(1, OS, 3'd2, 0, 0, 0, 4'b0000, 0, 2'b10, 2'b00, 2'b10, 4'd0, 0, 0);
        fd(OS, 3'd2, 0, 0, 1, 3'b001);
        v(1, OS, 3'd2, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0, 0);
        v(1, OS, 3'd2, 0, 0, 0, 4'b0010, 1, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
        v(1, OS, 3'd2, 0, 0, 1, 4'b0010, 1, 2'b00, 2'b00, 2'b00, 4'd0, 1, 0);
        // bge lt=1 not taken, bge lt=0 taken, bltu ltu=1 taken, bne zero=1 not taken
        fd(OB, 3'd5, 0, 3'b010, 1, 3'b010);
        v(1, OB, 3'd5, 0, 3'b010, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b00, 4'd1, 1, 0);
        fd(OB, 3'd5, 0, 3'b000, 1, 3'b010);
        v(1, OB, 3'd5, 0, 3'b000, 1, 4'b1000, 0, 2'b00, 2'b10, 2'b00, 4'd1, 1, 0);
        fd(OB, 3'd6, 0, 3'b001, 1, 3'b010);
        v(1, OB, 3'd6, 0, 3'b001, 1, 4'b1000, 0, 2'b00, 2'b10, 2'b00, 4'd1, 1, 0);
        fd(OB, 3'd1, 0, 3'b100, 1, 3'b010);
        v(1, OB, 3'd1, 0, 3'b100, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b00, 4'd1, 1, 0);
        // jal
        fd(OJ, 3'd0, 0, 0, 1, 3'b011);
        v(1, OJ, 3'd0, 0, 0, 1, 4'b1000, 0, 2'b00, 2'b01, 2'b10, 4'd0, 0, 0);
        wb(OJ, 3'd0, 0);
        // jalr
        fd(OJR, 3'd0, 0, 0, 1, 3'b000);
        v(1, OJR, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b01, 4'd0, 0, 0);
        v(1, OJR, 3'd0, 0, 0, 1, 4'b1000, 0, 2'b00, 2'b01, 2'b10, 4'd0, 0, 0);
        wb(OJR, 3'd0, 0);
        // lui, auipc
        fd(OLU, 3'd0, 0, 0, 1, 3'b100);
        v(1, OLU, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b11, 2'b01, 4'd0, 0, 0);
        wb(OLU, 3'd0, 0);
        fd(OAU, 3'd0, 0, 0, 1, 3'b100);
        v(1, OAU, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b01, 2'b01, 4'd0, 0, 0);
        wb(OAU, 3'd0, 0);
        // reset mid-EXECR: back to FETCH, count cleared, no writeback
        fd(OR_, 3'd0, 0, 0, 0, 3'b000);
        v(0, OR_, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b00, 4'd0, 0, 0);
        fd(OR_, 3'd0, 0, 0, 0, 3'b000);
        v(1, OR_, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b00, 4'd0, 0, 0);
        wb(OR_, 3'd0, 0);
        // branch funct3 010 traps
        fd(OB, 3'd2, 0, 3'b000, 1, 3'b010);
        v(1, OB, 3'd2, 0, 3'b000, 1, 4'b0000, 0, 2'b00, 2'b10, 2'b00, 4'd1, 0, 0);
        v(1, OB, 3'd2, 0, 3'b000, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
        v(1, OB, 3'd2, 0, 3'b000, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 1);
        v(1, OI, 3'd0, 0, 3'b000, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 1);
        v(0, OI, 3'd0, 0, 3'b000, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 1);
        // undefined opcode traps, stays trapped until reset
        fd(OBAD, 3'd0, 0, 0, 0, 3'b000);
        v(1, OBAD, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 0);
        v(1, OBAD, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 1);
        v(1, OR_, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 1);
        v(0, OR_, 3'd0, 0, 0, 1, 4'b0000, 0, 2'b00, 2'b00, 2'b00, 4'd0, 0, 1);

        @(posedge clk); #1;
        exp_cnt = 4'd0;
        foreach (vq[i]) begin
            rst_n = vq[i].rst; op = vq[i].op; funct3 = vq[i].f3; funct7b5 = vq[i].f7;
            {zero, lt, ltu} = vq[i].flg; mem_ready = vq[i].rdy;
            @(negedge clk);
            chk("ctrl", i,
                32'({PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ALUControl, instr_done}),
                32'({vq[i].en, vq[i].adr, vq[i].res, vq[i].a, vq[i].b, vq[i].alu, vq[i].done}));
            chk("instret", i, 32'(instret), 32'(exp_cnt));
            chk("illegal", i, 32'(illegal), 32'(vq[i].ill));
            if (vq[i].chk_imm) chk("immsrc", i, 32'(ImmSrc), 32'(vq[i].imm));
            @(posedge clk); #1;
            if (!vq[i].rst) exp_cnt = 4'd0;
            else if (vq[i].done) exp_cnt = exp_cnt + 4'd1;
        end

        // counter wrap: 16 taken beq retirements from a cleared count
        rst_n = 1'b1; op = OB; funct3 = 3'd0; funct7b5 = 1'b0;
        zero = 1'b1; lt = 1'b0; ltu = 1'b0; mem_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            repeat (2) begin @(posedge clk); #1; end
            @(negedge clk);
            chk("beq_taken", k, 32'({PCWrite, instr_done}), 32'(2'b11));
            @(posedge clk); #1;
            if (k == 14) chk("instret_max", k, 32'(instret), 32'd15);
            if (k == 15) chk("instret_wrap", k, 32'(instret), 32'd0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
